our_clk_div_multi: RTL
======================

Name: our_clk_div_multi

Overview:
- Multi-channel programmable clock divider; successor to the fixed single-output, compile-time divider.
- NCH independent channels, each with a runtime divisor and high-time (duty).
- Divisor/duty updates are glitch-free (applied only at a period boundary); each channel has a rising-edge tick strobe and a common phase-restart.
- Sits next to the system clock; feeds LED/display scan, UART baud and debounce timing blocks.

Parameters:
- NCH, 4, number of output channels (1..16).
- CNT_W, 32, width of counters and divisor/high registers.
- DEF_DIV, 10000, reset-time divisor of every channel (period in clk cycles).
- DEF_HIGH, 5000, reset-time high-phase length of every channel.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- ch_en  in  NCH  per-channel run enable (level).
- cfg_wr  in  1  one-cycle config write strobe.
- cfg_ch  in  $clog2(NCH) (min 1)  target channel of cfg_wr.
- cfg_div  in  CNT_W  new period in clk cycles.
- cfg_high  in  CNT_W  new high-phase length in clk cycles.
- sync_restart  in  1  pulse; restarts all enabled channels at count 0.
- clk_out  out  NCH  registered divided clocks.
- tick  out  NCH  one-cycle pulse coincident with each clk_out rising edge.
- cfg_pending  out  NCH  shadow config written but not yet applied.

Behaviour:
- Reset (async assert, sync release): cnt=0, active div=DEF_DIV, high=DEF_HIGH, shadow=active, running=0, clk_out=0, tick=0, cfg_pending=0.
- Per channel, while running: cnt counts 0..div-1, then wraps to 0.
- clk_out registered = running && (cnt < high). Period = div cycles; high time = high cycles.
- tick=1 in exactly the cycles where clk_out goes 0->1.
- Start: ch_en=1 while not running -> running=1 and cnt=0 next cycle; first clk_out rise one cycle later.
- Stop: ch_en=0 takes effect only at wrap (cnt==div-1): running=0, cnt=0, clk_out=0. No runt high pulse.
  - Re-asserting ch_en before the wrap cancels the stop.
- Config write: cfg_wr loads the shadow for cfg_ch and sets cfg_pending[cfg_ch]=1.
  - Shadow is copied to active at the next wrap, or immediately if the channel is not running; cfg_pending then clears.
  - A cfg_wr in the same cycle as the copy: the new write wins (shadow updated, pending stays 1).
  - A later write overwrites an earlier unapplied one.
  - cfg_ch >= NCH is ignored.
- Clamping, applied when the shadow is copied to active:
  - div < 2 -> 2.
  - high == 0 -> 1.
  - high >= div -> div-1 (uses the clamped div).
  - Guarantees a toggling output.
- sync_restart: every running channel sets cnt=0 next cycle and applies any pending shadow; non-running channels are unaffected.
  - sync_restart has priority over a wrap in the same cycle.
- Counter arithmetic: unsigned CNT_W; compare against div-1; no overflow is possible because the active div is clamped.
- Reset mid-operation: immediate return to reset values; pending config is lost.

Optional Feature:
- Macro: OUR_CLK_DIV_PHASE_EN.
- Defined:
  - Adds input cfg_phase (CNT_W), captured into the shadow with cfg_wr.
  - On sync_restart or start, cnt loads phase, clamped to div-1, instead of 0. Gives programmable inter-channel skew.
- Undefined: no port; start/restart always load 0.

Decomposition:
- Package our_clk_div_pkg:
  - CNT_W default.
  - DEF_DIV, DEF_HIGH.
  - Channel config struct typedef {div, high[, phase]}.
  - Clamp function.
- Sub-module our_clk_div_chan: one channel (counter, running flag, shadow/active config, clk_out/tick/pending).
- Top instantiates NCH copies via generate and decodes cfg_ch.

Test Plan:
- Reset, ch_en=0001 -> clk_out[0] rises 2 cycles after enable; period 10000, high 5000; tick once per 10000 cycles; other channels stay 0.
- cfg_wr ch1 div=7 high=3 while running at default -> cfg_pending[1]=1 until the next wrap, then period 7, high 3; no partial/short pulse at the switch.
- cfg_wr div=1 high=0, then div=5 high=9 -> active becomes div=2/high=1, then div=5/high=4.
- ch_en[2] dropped at cnt=10 of div=20 -> output completes the period, then clk_out=0, running=0; re-enable restarts with cnt=0.
- Channels 0,1 at div=6 and div=9; pulse sync_restart -> both clk_out rise together 2 cycles later; the same-cycle wrap is ignored.
- With OUR_CLK_DIV_PHASE_EN: ch0 phase=0, ch1 phase=3, div=8 high=4, sync_restart -> ch1 rises 5 cycles after ch0; rst_n pulse mid-run zeroes all outputs asynchronously.

Source files
------------

// File: rtl/our_clk_div_pkg.sv
// our_clk_div_pkg: shared width, reset defaults, channel config type and clamp helper.
// Build option: OUR_CLK_DIV_PHASE_EN adds a phase field to the channel config.
package our_clk_div_pkg;
  localparam int CNT_W = 32;
  localparam int DEF_DIV = 10000;
  localparam int DEF_HIGH = 5000;
  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
`ifdef OUR_CLK_DIV_PHASE_EN
    logic [CNT_W-1:0] phase;
`endif
  } cfg_t;
  // forces div >= 2 and 1 <= high < div so every channel toggles
  function automatic cfg_t clamp(input cfg_t c);
    cfg_t r;
    r = c;
    r.div = c.div < CNT_W'(2) ? CNT_W'(2) : c.div;
    r.high = c.high == '0 ? CNT_W'(1) : c.high;
    r.high = r.high >= r.div ? r.div - CNT_W'(1) : r.high;
`ifdef OUR_CLK_DIV_PHASE_EN
    r.phase = r.phase >= r.div ? r.div - CNT_W'(1) : r.phase;
`endif
    return r;
  endfunction
endpackage

// File: rtl/our_clk_div_chan.sv
// our_clk_div_chan: one divider channel with shadow/active config applied at period boundaries.
// Ports: clk, rst_n (async active-low), en_i run enable, wr_i shadow write, cfg_i config,
//        restart_i phase restart, clk_o divided clock, tick_o rise strobe, pend_o shadow pending.
// Build option: OUR_CLK_DIV_PHASE_EN makes start/restart load the configured phase.
module our_clk_div_chan
  import our_clk_div_pkg::*;
#(
  parameter logic [CNT_W-1:0] DIV0  = CNT_W'(DEF_DIV),
  parameter logic [CNT_W-1:0] HIGH0 = CNT_W'(DEF_HIGH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic wr_i,
  input  cfg_t cfg_i,
  input  logic restart_i,
  output logic clk_o,
  output logic tick_o,
  output logic pend_o
);
  localparam cfg_t RST_CFG = '{div: DIV0, high: HIGH0, default: '0};
  cfg_t act_q, act_d, shd_q, shd_d;
  logic run_q, run_d, pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
  logic wrap, rs, start, apply;
  logic [CNT_W-1:0] cnt_q, cnt_d, st;
  always_comb begin
    wrap   = run_q && cnt_q == act_q.div - CNT_W'(1);
    rs     = run_q && restart_i;
    start  = !run_q && en_i;
    // idle channels take the shadow at once; running ones only at a boundary
    apply  = pend_q && (!run_q || wrap || rs);
    act_d  = apply ? clamp(shd_q) : act_q;
    shd_d  = wr_i ? cfg_i : shd_q;
    // a write in the same cycle as a copy keeps the new value pending
    pend_d = wr_i || (pend_q && !apply);
`ifdef OUR_CLK_DIV_PHASE_EN
    st     = act_d.phase;
`else
    st     = '0;
`endif
    // restart outranks the wrap, so a pending stop waits for the next boundary
    run_d  = start || (run_q && (rs || !wrap || en_i));
    cnt_d  = (start || rs) ? st : (!run_q || wrap) ? '0 : cnt_q + CNT_W'(1);
    clk_d  = run_q && cnt_q < act_q.high;
    tick_d = clk_d && !clk_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      act_q  <= RST_CFG;
      shd_q  <= RST_CFG;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end
  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;
endmodule

// File: rtl/our_clk_div_multi.sv
// our_clk_div_multi: NCH-channel programmable clock divider with glitch-free runtime reconfiguration.
// Ports: clk, rst_n (async active-low), ch_en per-channel enable, cfg_wr/cfg_ch/cfg_div/cfg_high
//        config write, sync_restart common phase restart, clk_out divided clocks, tick rise strobes,
//        cfg_pending shadow-not-yet-applied flags.
// Build option: OUR_CLK_DIV_PHASE_EN adds cfg_phase, loaded as the start/restart count.
module our_clk_div_multi #(
  parameter int NCH      = 4,
  parameter int CNT_W    = our_clk_div_pkg::CNT_W,
  parameter int DEF_DIV  = our_clk_div_pkg::DEF_DIV,
  parameter int DEF_HIGH = our_clk_div_pkg::DEF_HIGH,
  localparam int CH_W    = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_en,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
`ifdef OUR_CLK_DIV_PHASE_EN
  input  logic [CNT_W-1:0] cfg_phase,
`endif
  input  logic             sync_restart,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   cfg_pending
);
  localparam int PW = our_clk_div_pkg::CNT_W;
  our_clk_div_pkg::cfg_t cfg;
  always_comb begin
    cfg = '0;
    cfg.div = PW'(cfg_div);
    cfg.high = PW'(cfg_high);
`ifdef OUR_CLK_DIV_PHASE_EN
    cfg.phase = PW'(cfg_phase);
`endif
  end
  // channel indices at or above NCH match no instance, so such writes are dropped
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    our_clk_div_chan #(
      .DIV0(PW'(DEF_DIV)),
      .HIGH0(PW'(DEF_HIGH))
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .en_i(ch_en[i]),
      .wr_i(cfg_wr && cfg_ch == CH_W'(i)),
      .cfg_i(cfg),
      .restart_i(sync_restart),
      .clk_o(clk_out[i]),
      .tick_o(tick[i]),
      .pend_o(cfg_pending[i])
    );
  end
endmodule
